// File: rtl/adder_arb_pkg.sv
// Shared types and sizing for the adder arbiter.
// Edit WIDTH/NUM_REQ here; ID_W and the typedefs follow automatically.
package adder_arb_pkg;
    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [ID_W-1:0]  req_id_t;
endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter. The search starts at ptr_q, and the pointer
// moves to one past the winner after each grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NUM_REQ requesters. It steers the granted
// operands to the adder and holds the sum, tagged with the requester ID, in a one-entry buffer.
module adder_arbiter
    import adder_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_p,
    input  logic [NUM_REQ*WIDTH-1:0] req_q,
    output logic [NUM_REQ-1:0]       req_ready,
    output word_t                    add_p,
    output word_t                    add_q,
    input  word_t                    add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output word_t                    rsp_sum,
    output req_id_t                  rsp_id
);
    logic               rsp_valid_q, rsp_valid_d;
    word_t              rsp_sum_q, rsp_sum_d;
    req_id_t            rsp_id_q, rsp_id_d;
    logic               can_accept;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    req_id_t            grant_id;

    // A draining buffer can take a new result on the same edge.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign arb_en     = can_accept && !reset;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .enable  (arb_en),
        .grant   (grant),
        .grant_id(grant_id)
    );

    assign req_ready = grant;

    always_comb begin
        add_p = '0;
        add_q = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                add_p = req_p[i*WIDTH +: WIDTH];
                add_q = req_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (|grant) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_id_d    = grant_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter. The reference model tracks the round-robin
// pointer and the response buffer with plain integers. The bench also models the shared adder.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_p, req_q;
    word_t                    add_p, add_q, add_sum, rsp_sum;
    logic                     rsp_valid, rsp_ready;
    req_id_t                  rsp_id;

    word_t op_p [NUM_REQ];
    word_t op_q [NUM_REQ];

    int    n_pass = 0;
    int    n_chk  = 0;
    int    m_ptr;
    logic  m_valid;
    word_t m_sum;
    int    m_id;

    always #5 clk = ~clk;

    always_comb begin
        req_p = '0;
        req_q = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_p[i*WIDTH +: WIDTH] = op_p[i];
            req_q[i*WIDTH +: WIDTH] = op_q[i];
        end
    end

    assign add_sum = add_p + add_q;

    adder_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_p    (req_p),
        .req_q    (req_q),
        .req_ready(req_ready),
        .add_p    (add_p),
        .add_q    (add_q),
        .add_sum  (add_sum),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id)
    );

    function automatic word_t rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) r[i] = (i == g);
        return r;
    endfunction

    function automatic word_t pick(input int g, input logic sel_q);
        word_t r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) if (i == g) r = sel_q ? op_q[i] : op_p[i];
        return r;
    endfunction

    // Who should win right now: first valid requester at or after the pointer,
    // provided the buffer is empty or being drained.
    function automatic int model_grant();
        int i;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick(output int g);
        g = model_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_sum   = pick(g, 1'b0) + pick(g, 1'b1);
            m_id    = g;
            m_ptr   = (g + 1) % NUM_REQ;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_id = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        req_valid = '1; rsp_ready = 1'b1;
        #1;
        if (req_ready !== '0) $display("FAIL rst_ready got %b exp 0", req_ready); else n_pass++; n_chk++;
        if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rsp_valid); else n_pass++; n_chk++;
        if (rsp_sum !== '0) $display("FAIL rst_sum got %h exp 0", rsp_sum); else n_pass++; n_chk++;
        if (rsp_id !== '0) $display("FAIL rst_id got %0d exp 0", rsp_id); else n_pass++; n_chk++;
        @(posedge clk); #1;
        if (req_ready !== '0) $display("FAIL rst_ready_edge got %b exp 0", req_ready); else n_pass++; n_chk++;
        if (rsp_valid !== 1'b0) $display("FAIL rst_valid_edge got %b exp 0", rsp_valid); else n_pass++; n_chk++;
        reset = 1'b0; req_valid = '0;
        model_reset();
    endtask

    task automatic test_single();
        int g;
        req_valid = 3'b001; op_p[0] = 64'd5; op_q[0] = 64'd7; rsp_ready = 1'b1;
        #1;
        if (req_ready !== 3'b001) $display("FAIL single_grant got %b exp 001", req_ready); else n_pass++; n_chk++;
        if (add_p !== 64'd5 || add_q !== 64'd7) $display("FAIL single_operands got %h/%h exp 5/7", add_p, add_q); else n_pass++; n_chk++;
        tick(g);
        req_valid = '0;
        if (rsp_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", rsp_valid); else n_pass++; n_chk++;
        if (rsp_sum !== 64'd12) $display("FAIL single_sum got %0d exp 12", rsp_sum); else n_pass++; n_chk++;
        if (rsp_id !== 2'd0) $display("FAIL single_id got %0d exp 0", rsp_id); else n_pass++; n_chk++;
        #1;
        if (req_ready !== '0 || add_p !== '0) $display("FAIL idle_outputs got %b/%h exp 0/0", req_ready, add_p); else n_pass++; n_chk++;
    endtask

    task automatic test_round_robin();
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin op_p[i] = rnd64(); op_q[i] = rnd64(); end
        req_valid = '1; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = onehot(k % NUM_REQ);
            #1;
            if (req_ready !== exp_rdy) $display("FAIL rr_grant_%0d got %b exp %b", k, req_ready, exp_rdy); else n_pass++; n_chk++;
            tick(g);
            for (int i = 0; i < NUM_REQ; i++) if (i == g) begin op_p[i] = rnd64(); op_q[i] = rnd64(); end
            if (rsp_valid !== 1'b1 || rsp_id !== req_id_t'(k % NUM_REQ))
                $display("FAIL rr_rsp_id_%0d got %b/%0d exp 1/%0d", k, rsp_valid, rsp_id, k % NUM_REQ); else n_pass++; n_chk++;
            if (rsp_sum !== m_sum) $display("FAIL rr_rsp_sum_%0d got %h exp %h", k, rsp_sum, m_sum); else n_pass++; n_chk++;
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        rsp_ready = 1'b0;
        #1;
        if (req_ready !== '0) $display("FAIL bp_block got %b exp 0", req_ready); else n_pass++; n_chk++;
        for (int k = 0; k < 4; k++) begin
            tick(g);
            if (req_ready !== '0) $display("FAIL bp_ready_%0d got %b exp 0", k, req_ready); else n_pass++; n_chk++;
            if (rsp_valid !== 1'b1 || rsp_sum !== m_sum || rsp_id !== req_id_t'(m_id))
                $display("FAIL bp_hold_%0d got %b/%h/%0d exp 1/%h/%0d", k, rsp_valid, rsp_sum, rsp_id, m_sum, m_id); else n_pass++; n_chk++;
        end
        rsp_ready = 1'b1;
        #1;
        exp_rdy = onehot(model_grant());
        if (req_ready !== exp_rdy) $display("FAIL bp_release got %b exp %b", req_ready, exp_rdy); else n_pass++; n_chk++;
        tick(g);
        if (rsp_id !== req_id_t'(m_id) || rsp_sum !== m_sum)
            $display("FAIL bp_after got %0d/%h exp %0d/%h", rsp_id, rsp_sum, m_id, m_sum); else n_pass++; n_chk++;
        req_valid = '0;
    endtask

    task automatic test_arith();
        int g;
        word_t p_tab [2];
        word_t s_tab [2];
        p_tab[0] = 64'hFFFF_FFFF_FFFF_FFFF; s_tab[0] = 64'h0;
        p_tab[1] = 64'h7FFF_FFFF_FFFF_FFFF; s_tab[1] = 64'h8000_0000_0000_0000;
        rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            req_valid = 3'b001; op_p[0] = p_tab[t]; op_q[0] = 64'd1;
            #1;
            tick(g);
            req_valid = '0;
            if (rsp_sum !== s_tab[t]) $display("FAIL arith_%0d got %h exp %h", t, rsp_sum, s_tab[t]); else n_pass++; n_chk++;
        end
    endtask

    task automatic test_pointer_wrap();
        int g;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin op_p[i] = rnd64(); op_q[i] = rnd64(); end
        req_valid = 3'b001;
        #1;
        if (req_ready !== 3'b001) $display("FAIL wrap_first got %b exp 001", req_ready); else n_pass++; n_chk++;
        tick(g);
        req_valid = 3'b100;
        #1;
        if (req_ready !== 3'b100) $display("FAIL wrap_req2 got %b exp 100", req_ready); else n_pass++; n_chk++;
        tick(g);
        if (rsp_id !== 2'd2) $display("FAIL wrap_id got %0d exp 2", rsp_id); else n_pass++; n_chk++;
        req_valid = 3'b011;
        #1;
        if (req_ready !== 3'b001) $display("FAIL wrap_ptr0 got %b exp 001", req_ready); else n_pass++; n_chk++;
        tick(g);
        req_valid = 3'b010;
        #1;
        if (req_ready !== 3'b010) $display("FAIL wrap_req1 got %b exp 010", req_ready); else n_pass++; n_chk++;
        tick(g);
        req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    op_p[i] = ($urandom_range(0, 7) == 0) ? '1 : rnd64();
                    op_q[i] = rnd64();
                end
            end
            #1;
            g = model_grant();
            exp_rdy = onehot(g);
            if (req_ready !== exp_rdy) $display("FAIL rand_grant_%0d got %b exp %b", c, req_ready, exp_rdy); else n_pass++; n_chk++;
            if (add_p !== pick(g, 1'b0) || add_q !== pick(g, 1'b1))
                $display("FAIL rand_operands_%0d got %h/%h exp %h/%h", c, add_p, add_q, pick(g, 1'b0), pick(g, 1'b1)); else n_pass++; n_chk++;
            tick(g);
            req_valid = req_valid & ~onehot(g);
            if (rsp_valid !== m_valid) $display("FAIL rand_valid_%0d got %b exp %b", c, rsp_valid, m_valid); else n_pass++; n_chk++;
            if (m_valid) begin
                if (rsp_id !== req_id_t'(m_id) || rsp_sum !== m_sum)
                    $display("FAIL rand_rsp_%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_sum, m_id, m_sum); else n_pass++; n_chk++;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int g;
        for (int i = 0; i < NUM_REQ; i++) begin op_p[i] = rnd64(); op_q[i] = rnd64(); end
        req_valid = '1; rsp_ready = 1'b1;
        #1;
        tick(g);
        rsp_ready = 1'b0;
        #1;
        if (rsp_valid !== m_valid) $display("FAIL mid_pending got %b exp %b", rsp_valid, m_valid); else n_pass++; n_chk++;
        reset = 1'b1;
        #1;
        if (rsp_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", rsp_valid); else n_pass++; n_chk++;
        if (req_ready !== '0) $display("FAIL mid_ready got %b exp 0", req_ready); else n_pass++; n_chk++;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        rsp_ready = 1'b1;
        #1;
        if (req_ready !== 3'b001) $display("FAIL mid_restart got %b exp 001", req_ready); else n_pass++; n_chk++;
        tick(g);
        if (rsp_id !== 2'd0 || rsp_sum !== m_sum) $display("FAIL mid_rsp got %0d/%h exp 0/%h", rsp_id, rsp_sum, m_sum); else n_pass++; n_chk++;
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin op_p[i] = '0; op_q[i] = '0; end
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_arith();
        test_pointer_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
